// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: sequential AES byte-substitution engine.
// Substitutes an NBYTES-wide word through LANES shared S-box lookups per cycle,
// taking NBYTES/LANES passes, with valid/ready handshakes on input and output.
// Optional feature macro: INV_SBOX_EN (inverse S-box table, selected per word by in_inv).
module sub_bytes_seq #(
   parameter int unsigned NBYTES = 4,
   parameter int unsigned LANES  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NBYTES-1:0] in_data,
   input  logic                in_inv,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NBYTES-1:0] out_data,
   output logic                busy
);

   localparam int unsigned W  = 8 * NBYTES;
   localparam int unsigned P  = NBYTES / LANES;
   localparam int unsigned CW = (P > 1) ? $clog2(P) : 1;
   localparam logic [CW-1:0] LAST = CW'(P - 1);

   // Reject configurations where the lanes do not tile the word exactly
   generate
      if (NBYTES < 1 || NBYTES > 16 || LANES < 1 || (NBYTES % LANES) != 0) begin : g_bad_cfg
         $error("sub_bytes_seq: NBYTES must be 1..16 and divisible by LANES");
      end
   endgenerate

   // Forward S-box, entry 0x00 in the top byte
   localparam logic [2047:0] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

`ifdef INV_SBOX_EN
   // Inverse S-box, entry 0x00 in the top byte
   localparam logic [2047:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] f_inv(input logic [7:0] x);
      return SBOX_INV[{~x, 3'b000} +: 8];
   endfunction
`endif

   function automatic logic [7:0] f_fwd(input logic [7:0] x);
      return SBOX_FWD[{~x, 3'b000} +: 8];
   endfunction

   // Bit offset of the byte handled by a lane in the current pass (byte 0 = MSB)
   function automatic int unsigned f_shift(input logic [CW-1:0] cnt, input int unsigned lane);
      return 8 * (NBYTES - 1 - (32'(cnt) * LANES + lane));
   endfunction

   function automatic logic [7:0] f_pick(input logic [W-1:0] w, input int unsigned sh);
      return 8'(w >> sh);
   endfunction

   function automatic logic [W-1:0] f_place(input logic [W-1:0] w, input logic [7:0] b,
                                            input int unsigned sh);
      return (w & ~(W'(8'hFF) << sh)) | (W'(b) << sh);
   endfunction

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [W-1:0]   r_work;
   logic [W-1:0]   w_work_nxt;
   logic [CW-1:0]  r_cnt;
   logic           w_load;
   logic           w_pass;

`ifdef INV_SBOX_EN
   logic           r_inv;
`else
   logic           w_unused_inv;
   assign w_unused_inv = in_inv;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)       w_state_nxt = S_BUSY;
         S_BUSY:  if (r_cnt == LAST)  w_state_nxt = S_DONE;
         S_DONE:  if (out_ready)      w_state_nxt = S_IDLE;
         default:                     w_state_nxt = S_IDLE;
      endcase
   end

   // Output and datapath-control decode of the registered state
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      w_load    = 1'b0;
      w_pass    = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            w_load   = in_valid;
         end
         S_BUSY: begin
            busy   = 1'b1;
            w_pass = 1'b1;
         end
         S_DONE: begin
            out_valid = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   // Shared S-box lanes: substitute this pass's bytes in place
   always_comb begin
      w_work_nxt = r_work;
      for (int unsigned l = 0; l < LANES; l++) begin
`ifdef INV_SBOX_EN
         w_work_nxt = f_place(w_work_nxt,
                              r_inv ? f_inv(f_pick(r_work, f_shift(r_cnt, l)))
                                    : f_fwd(f_pick(r_work, f_shift(r_cnt, l))),
                              f_shift(r_cnt, l));
`else
         w_work_nxt = f_place(w_work_nxt,
                              f_fwd(f_pick(r_work, f_shift(r_cnt, l))),
                              f_shift(r_cnt, l));
`endif
      end
   end

   // Work register and pass counter; counter saturates at the last pass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work <= '0;
         r_cnt  <= '0;
      end else if (w_load) begin
         r_work <= in_data;
         r_cnt  <= '0;
      end else if (w_pass) begin
         r_work <= w_work_nxt;
         if (r_cnt != LAST) begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

`ifdef INV_SBOX_EN
   // Direction latched with the word so later in_inv changes have no effect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inv <= 1'b0;
      end else if (w_load) begin
         r_inv <= in_inv;
      end
   end
`endif

   assign out_data = r_work;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Scoreboard bench for sub_bytes_seq: three configurations (4/1, 4/2, 16/4),
// each with its own driver, monitor and expected-result queue.
module tb_sub_bytes_seq;

`ifdef INV_SBOX_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   localparam logic [127:0] DIR_IN  [3] = '{128'hCF4F3C09, 128'h005301FF,
                                           128'h00102030405060708090A0B0C0D0E0F0};
   localparam logic [127:0] DIR_OUT [3] = '{128'h8A84EB01, 128'h63ED7C16,
                                           128'h63CAB7040953D051CD60E0E7BA70E18C};

   logic clk;
   int   n_pass = 0;
   int   n_chk  = 0;
   logic [7:0] fwd_t [256];
   logic [7:0] inv_t [256];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, got, exp);
   endtask

   task automatic fail_to(input string nm);
      n_chk++;
      $display("FAIL %s: got timeout, expected DUT event", nm);
   endtask

   // GF(2^8) arithmetic for the reference S-box
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, x;
      r = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] t;
      t = {v, v} << n;
      return t[15:8];
   endfunction

   // S(x) = affine(x^-1), with 0 mapping to 0 before the affine step
   function automatic logic [7:0] sbox_math(input logic [7:0] x);
      logic [7:0] b;
      b = 8'h01;
      if (x == 8'h00) b = 8'h00;
      else for (int i = 0; i < 254; i++) b = gmul(b, x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) begin
         fwd_t[i] = sbox_math(8'(i));
         inv_t[fwd_t[i]] = 8'(i);
      end
   end

   function automatic logic [127:0] model(input logic [127:0] d, input int nb, input bit inv);
      logic [127:0] r;
      logic [7:0]   x;
      r = '0;
      for (int b = 0; b < nb; b++) begin
         x = d[8*b +: 8];
         r[8*b +: 8] = inv ? inv_t[x] : fwd_t[x];
      end
      return r;
   endfunction

   function automatic logic [127:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int unsigned NB = (g == 0) ? 4 : ((g == 1) ? 4 : 16);
      localparam int unsigned LN = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      localparam int unsigned P  = NB / LN;
      localparam int unsigned W  = 8 * NB;

      logic          rst_n_l, in_valid, in_ready, in_inv, out_valid, out_ready, busy;
      logic [W-1:0]  in_data, out_data;
      logic [127:0]  exp_q [$];
      logic [1:0]    rmode;   // 0 random out_ready, 1 hold low, 2 hold high
      logic          done_l;

      sub_bytes_seq #(.NBYTES(NB), .LANES(LN)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n_l),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_data   (in_data),
         .in_inv    (in_inv),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out_data  (out_data),
         .busy      (busy)
      );

      task automatic wait_ready();
         int n = 0;
         @(negedge clk);
         while (!in_ready && n < 300) begin @(negedge clk); n++; end
         if (!in_ready) fail_to("wait_ready");
      endtask

      task automatic send(input logic [127:0] d, input bit inv, input logic [127:0] e);
         wait_ready();
         in_valid = 1'b1;
         in_data  = W'(d);
         in_inv   = inv;
         @(posedge clk);
         exp_q.push_back(e);
         #1 in_valid = 1'b0;
      endtask

      task automatic wait_valid(output int n);
         n = 0;
         do begin @(negedge clk); n++; end while (!out_valid && n < 300);
         if (!out_valid) fail_to("wait_valid");
      endtask

      task automatic drain();
         int n = 0;
         while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
         if (exp_q.size() != 0) fail_to("drain");
      endtask

      // Monitor: choose out_ready, compare whenever a handshake is about to occur
      initial begin : mon
         out_ready = 1'b0;
         forever begin
            @(negedge clk);
            case (rmode)
               2'd0:    out_ready = ($urandom_range(0, 3) != 0);
               2'd1:    out_ready = 1'b0;
               default: out_ready = 1'b1;
            endcase
            if (rst_n_l && out_valid && out_ready) begin
               if (exp_q.size() == 0) fail_to("unexpected_output");
               else chk("out_data", 128'(out_data), exp_q.pop_front());
            end
         end
      end

      // Driver: reset, directed vectors, backpressure, mid-busy reset, back-to-back, random
      initial begin : drv
         int            n;
         logic [127:0]  d, e, msk;
         bit            inv;
         done_l   = 1'b0;
         rst_n_l  = 1'b0;
         in_valid = 1'b0;
         in_data  = '0;
         in_inv   = 1'b0;
         rmode    = 2'd2;
         msk = (W == 128) ? '1 : ((128'(1) << W) - 128'(1));
         repeat (2) @(posedge clk);
         #1;
         chk("rst_in_ready",  128'(in_ready),  128'(1));
         chk("rst_out_valid", 128'(out_valid), 128'(0));
         chk("rst_busy",      128'(busy),      128'(0));
         chk("rst_out_data",  128'(out_data),  128'(0));
         @(negedge clk);
         rst_n_l = 1'b1;

         send(DIR_IN[g], 1'b0, DIR_OUT[g]);
         wait_valid(n);
         chk("latency", 128'(n), 128'(P + 1));
         drain();

         d = {4{32'h63ED7C16}} & msk;
         e = (INV_EN ? {4{32'h005301FF}} : {4{32'hFB551047}}) & msk;
         send(d, 1'b1, e);
         drain();

         rmode = 2'd1;
         send(DIR_IN[g], 1'b0, DIR_OUT[g]);
         wait_valid(n);
         for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", 128'(out_valid), 128'(1));
            chk("hold_in_ready",  128'(in_ready),  128'(0));
            chk("hold_out_data",  128'(out_data),  DIR_OUT[g]);
            in_valid = (i % 2 == 0);
            in_data  = W'(~DIR_IN[g]);
            in_inv   = 1'b1;
            @(negedge clk);
         end
         in_valid = 1'b0;
         rmode    = 2'd2;
         drain();

         rmode = 2'd0;
         d = rnd();
         send(d, 1'b0, model(d, NB, 1'b0));
         @(posedge clk);
         #2 rst_n_l = 1'b0;
         #1;
         chk("midrst_out_valid", 128'(out_valid), 128'(0));
         chk("midrst_busy",      128'(busy),      128'(0));
         chk("midrst_in_ready",  128'(in_ready),  128'(1));
         chk("midrst_out_data",  128'(out_data),  128'(0));
         exp_q.delete();
         @(negedge clk);
         rst_n_l = 1'b1;
         send(DIR_IN[g], 1'b0, DIR_OUT[g]);
         drain();

         rmode = 2'd2;
         d = rnd();
         e = rnd();
         wait_ready();
         in_valid = 1'b1;
         in_data  = W'(d);
         in_inv   = 1'b0;
         @(posedge clk);
         exp_q.push_back(model(d, NB, 1'b0));
         #1 in_data = W'(e);
         n = 0;
         do begin @(negedge clk); n++; end while (!in_ready && n < 300);
         chk("b2b_accept_gap", 128'(n), 128'(P + 2));
         @(posedge clk);
         exp_q.push_back(model(e, NB, 1'b0));
         #1 in_valid = 1'b0;
         drain();

         rmode = 2'd0;
         for (int k = 0; k < 25; k++) begin
            d   = rnd();
            inv = ($urandom_range(0, 1) == 1);
            send(d, inv, model(d, NB, inv && INV_EN));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         drain();
         chk("queue_empty", 128'(exp_q.size()), 128'(0));
         done_l = 1'b1;
      end
   end

   initial begin : main
      int cyc = 0;
      while (!(g_cfg[0].done_l === 1'b1 && g_cfg[1].done_l === 1'b1 && g_cfg[2].done_l === 1'b1)
             && cyc < 60000) begin
         @(posedge clk);
         cyc++;
      end
      if (cyc >= 60000) fail_to("global_timeout");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
